vga_ctrl: RTL and testbench
===========================

VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 Parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-002 Parameter H_ACT_START, default 144, first active pixel column of the line counter.
REQ-003 Parameter H_ACT_END, default 784, first inactive column after the active region.
REQ-004 Parameter H_TOTAL, default 800, pixels per line.
REQ-005 Parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-006 Parameter V_ACT_START, default 35, first active line.
REQ-007 Parameter V_ACT_END, default 515, first inactive line after the active region.
REQ-008 Parameter V_TOTAL, default 525, lines per frame.
REQ-009 Parameter PIPE_DLY, default 2, range 0..7; clk cycles between h_addr/v_addr and the matching vga_data.
REQ-010 clk  input  1  system clock, rising edge.
REQ-011 rst  input  1  reset, asynchronous, active-low.
REQ-012 pclk_en  input  1  pixel-advance enable; counters step only when high.
REQ-013 vga_data  input  24  pixel colour {R,G,B} from the pixel-source stage.
REQ-014 h_addr  output  10  active-region column 0..639, 0 outside the active region.
REQ-015 v_addr  output  10  active-region row 0..479, 0 outside the active region.
REQ-016 valid  output  1  undelayed active-region flag aligned with h_addr/v_addr.
REQ-017 frame_start  output  1  one-clk pulse when the counters wrap to (0,0).
REQ-018 hsync  output  1  active-low line sync, delayed by PIPE_DLY.
REQ-019 vsync  output  1  active-low frame sync, delayed by PIPE_DLY.
REQ-020 blank_n  output  1  delayed valid; high while pixels are displayed.
REQ-021 vga_r, vga_g, vga_b  output  8 each  colour output, registered.

Function
REQ-022 x_cnt (0..H_TOTAL-1) SHALL increment on clk when pclk_en=1, and SHALL wrap to 0 after H_TOTAL-1.
REQ-023 y_cnt (0..V_TOTAL-1) SHALL increment when x_cnt wraps, and SHALL wrap to 0 after V_TOTAL-1.
REQ-024 When pclk_en=0, x_cnt, y_cnt, h_addr, v_addr and valid SHALL hold their values.
REQ-025 valid SHALL be high iff H_ACT_START<=x_cnt<H_ACT_END and V_ACT_START<=y_cnt<V_ACT_END.
REQ-026 h_addr SHALL equal x_cnt-H_ACT_START and v_addr SHALL equal y_cnt-V_ACT_START while valid=1; otherwise both SHALL be 0. Arithmetic is 10-bit unsigned with no wrap.
REQ-027 The raw hsync SHALL be 0 iff x_cnt<H_SYNC; the raw vsync SHALL be 0 iff y_cnt<V_SYNC.
REQ-028 The registered outputs h_addr, v_addr and valid SHALL be derived combinationally from the current counters.
REQ-029 frame_start SHALL be high for exactly one clk cycle, in the cycle after a pclk_en edge moves the counters from (H_TOTAL-1, V_TOTAL-1) to (0,0).
REQ-030 Raw hsync, vsync and valid SHALL pass through a PIPE_DLY-stage shift register that advances every clk cycle, independent of pclk_en.
REQ-031 With PIPE_DLY=0, the raw values SHALL drive the outputs directly.
REQ-032 {vga_r,vga_g,vga_b} SHALL register vga_data when delayed valid=1, and SHALL register 0 otherwise, so that no colour appears during blanking.
REQ-033 Counter wrap and valid transitions occurring in the same cycle SHALL both take effect; no special precedence is required.

Reset
REQ-034 While rst=0, the block SHALL set x_cnt=0, y_cnt=0, h_addr=0, v_addr=0, valid=0, frame_start=0, all delay stages to hsync=1 / vsync=1 / blank_n=0, and vga_r/g/b=0.
REQ-035 After rst deasserts, counting SHALL resume from (0,0) at the first clk edge with pclk_en=1.
REQ-036 An assertion of rst mid-frame SHALL clear the block immediately (asynchronously), with no partial-line completion.

Verification
REQ-037 Defaults, pclk_en=1 constantly, run one full frame: exactly 420000 clk cycles between frame_start pulses; 525 hsync pulses of 96 cycles each; vsync low for 1600 cycles.
REQ-038 Active-region check: count valid=1 cycles per frame = 307200; first valid cycle has h_addr=0, v_addr=0 at x_cnt=144, y_cnt=35; last has h_addr=639, v_addr=479.
REQ-039 PIPE_DLY=2, vga_data=24'hFFFFFF constant: blank_n rises exactly 2 clk after valid; vga_r/g/b=FF,FF,FF exactly 3 clk after valid rises; all 0 whenever blank_n=0.
REQ-040 pclk_en toggling 1,0,1,0: period between frame_start pulses = 840000 clk; h_addr holds for 2 clk per step; hsync width = 192 clk.
REQ-041 Assert rst at x_cnt=400, y_cnt=200 with pclk_en=1: outputs reach reset values without a clk edge; after release, first frame_start arrives after 420000 pixel steps.
REQ-042 Wrap corner: at x_cnt=799, y_cnt=524 plus one pclk_en edge, the counters become (0,0), frame_start=1 for one clk, and valid stays 0.

Source files
------------

// File: rtl/vga_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vga_ctrl
//  Purpose  : VGA timing generator. It runs pixel/line counters gated by
//             pclk_en, produces active-region addresses, and delays the sync
//             and blanking signals so they line up with the pixel-source data.
//  Revision : 1.0  initial release
// ============================================================================
module vga_ctrl #(
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515,
    parameter int V_TOTAL     = 525,
    parameter int PIPE_DLY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pclk_en,
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        valid,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    localparam logic [9:0] c_H_SYNC      = 10'(H_SYNC);
    localparam logic [9:0] c_H_ACT_START = 10'(H_ACT_START);
    localparam logic [9:0] c_H_ACT_END   = 10'(H_ACT_END);
    localparam logic [9:0] c_H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_SYNC      = 10'(V_SYNC);
    localparam logic [9:0] c_V_ACT_START = 10'(V_ACT_START);
    localparam logic [9:0] c_V_ACT_END   = 10'(V_ACT_END);
    localparam logic [9:0] c_V_LAST      = 10'(V_TOTAL - 1);

    logic [9:0]  r_x_cnt;
    logic [9:0]  r_y_cnt;
    logic [9:0]  r_h_addr;
    logic [9:0]  r_v_addr;
    logic        r_valid;
    logic        r_frame_start;
    logic [23:0] r_rgb;

    logic [9:0]  w_x_nxt;
    logic [9:0]  w_y_nxt;
    logic [9:0]  w_h_nxt;
    logic [9:0]  w_v_nxt;
    logic        w_x_wrap;
    logic        w_act_nxt;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic        w_hs_dly;
    logic        w_vs_dly;
    logic        w_blank_dly;

    // Next counter position and the address/valid that belong to it, so the
    // address registers always describe the counters they are stored with.
    always_comb begin
        w_x_wrap = (r_x_cnt == c_H_LAST);
        w_x_nxt  = w_x_wrap ? 10'd0 : r_x_cnt + 10'd1;
        w_y_nxt  = r_y_cnt;
        if (w_x_wrap) begin
            w_y_nxt = (r_y_cnt == c_V_LAST) ? 10'd0 : r_y_cnt + 10'd1;
        end
        w_act_nxt = (w_x_nxt >= c_H_ACT_START) && (w_x_nxt < c_H_ACT_END) &&
                    (w_y_nxt >= c_V_ACT_START) && (w_y_nxt < c_V_ACT_END);
        w_h_nxt = 10'd0;
        w_v_nxt = 10'd0;
        if (w_act_nxt) begin
            w_h_nxt = w_x_nxt - c_H_ACT_START;
            w_v_nxt = w_y_nxt - c_V_ACT_START;
        end
    end

    // Counters and active-region registers step only on pixel-enable cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x_cnt  <= 10'd0;
            r_y_cnt  <= 10'd0;
            r_h_addr <= 10'd0;
            r_v_addr <= 10'd0;
            r_valid  <= 1'b0;
        end else if (pclk_en) begin
            r_x_cnt  <= w_x_nxt;
            r_y_cnt  <= w_y_nxt;
            r_h_addr <= w_h_nxt;
            r_v_addr <= w_v_nxt;
            r_valid  <= w_act_nxt;
        end
    end

    // One-clk pulse in the cycle the counters land on (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= pclk_en && (r_x_cnt == c_H_LAST) && (r_y_cnt == c_V_LAST);
        end
    end

    // Raw active-low syncs straight from the counters.
    assign w_hs_raw = (r_x_cnt >= c_H_SYNC);
    assign w_vs_raw = (r_y_cnt >= c_V_SYNC);

    generate
        if (PIPE_DLY == 0) begin : g_no_pipe
            assign w_hs_dly    = w_hs_raw;
            assign w_vs_dly    = w_vs_raw;
            assign w_blank_dly = r_valid;
        end else begin : g_pipe
            // Bits per stage are {hsync, vsync, blank_n}.
            logic [PIPE_DLY-1:0][2:0] r_pipe;

            // Free-running delay line matching the pixel-source latency.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_pipe <= {PIPE_DLY{3'b110}};
                end else begin
                    r_pipe[0] <= {w_hs_raw, w_vs_raw, r_valid};
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_hs_dly    = r_pipe[PIPE_DLY-1][2];
            assign w_vs_dly    = r_pipe[PIPE_DLY-1][1];
            assign w_blank_dly = r_pipe[PIPE_DLY-1][0];
        end
    endgenerate

    // Colour register forced to black whenever the delayed blank is active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgb <= 24'd0;
        end else begin
            r_rgb <= w_blank_dly ? vga_data : 24'd0;
        end
    end

    assign h_addr      = r_h_addr;
    assign v_addr      = r_v_addr;
    assign valid       = r_valid;
    assign frame_start = r_frame_start;
    assign hsync       = w_hs_dly;
    assign vsync       = w_vs_dly;
    assign blank_n     = w_blank_dly;
    assign vga_r       = r_rgb[23:16];
    assign vga_g       = r_rgb[15:8];
    assign vga_b       = r_rgb[7:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_ctrl
//  Purpose  : Self-checking bench for vga_ctrl on a reduced timing so whole
//             frames fit in a short run; outputs compared against a
//             position-based reference model every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_ctrl;

    localparam int HS    = 4;
    localparam int HAS   = 6;
    localparam int HAE   = 14;
    localparam int HT    = 16;
    localparam int VS    = 2;
    localparam int VAS   = 3;
    localparam int VAE   = 8;
    localparam int VT    = 10;
    localparam int D     = 2;
    localparam int FRAME = HT * VT;
    localparam logic [48:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pclk_en = 1'b0;
    logic [23:0] vga_data = 24'd0;
    logic [9:0]  h_addr, v_addr;
    logic        valid, frame_start, hsync, vsync, blank_n;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [48:0] act_vec;

    always #5 clk = ~clk;

    vga_ctrl #(
        .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_END(HAE), .H_TOTAL(HT),
        .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT_END(VAE), .V_TOTAL(VT),
        .PIPE_DLY(D)
    ) dut (
        .clk(clk), .rst(rst), .pclk_en(pclk_en), .vga_data(vga_data),
        .h_addr(h_addr), .v_addr(v_addr), .valid(valid),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
        .blank_n(blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    assign act_vec = {h_addr, v_addr, valid, frame_start, hsync, vsync, blank_n,
                      vga_r, vga_g, vga_b};

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: position is just the number of pixel steps taken.
    int          m_n;
    bit          m_fs, m_hs, m_vs, m_blank;
    logic [23:0] m_rgb;
    logic [2:0]  m_hist[$];

    function automatic int m_x(input int n);
        return n % HT;
    endfunction

    function automatic int m_y(input int n);
        return (n / HT) % VT;
    endfunction

    function automatic bit m_act(input int n);
        return (m_x(n) >= HAS) && (m_x(n) < HAE) && (m_y(n) >= VAS) && (m_y(n) < VAE);
    endfunction

    function automatic logic [48:0] exp_vec();
        logic [9:0] h;
        logic [9:0] v;
        h = 10'd0;
        v = 10'd0;
        if (m_act(m_n)) begin
            h = 10'(m_x(m_n) - HAS);
            v = 10'(m_y(m_n) - VAS);
        end
        return {h, v, m_act(m_n), m_fs, m_hs, m_vs, m_blank, m_rgb};
    endfunction

    task automatic model_reset();
        m_n = 0; m_fs = 0; m_hs = 1; m_vs = 1; m_blank = 0; m_rgb = 24'd0;
        m_hist.delete();
    endtask

    task automatic model_edge(input bit en, input logic [23:0] d);
        logic [2:0] raw;
        m_rgb = m_blank ? d : 24'd0;
        m_hist.push_back({m_x(m_n) >= HS, m_y(m_n) >= VS, m_act(m_n)});
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        m_fs = en && ((m_n % FRAME) == FRAME - 1);
        if (en) m_n++;
        if (D == 0) begin
            raw = {m_x(m_n) >= HS, m_y(m_n) >= VS, m_act(m_n)};
            {m_hs, m_vs, m_blank} = raw;
        end else if (m_hist.size() >= D) begin
            {m_hs, m_vs, m_blank} = m_hist[m_hist.size() - D];
        end else begin
            {m_hs, m_vs, m_blank} = 3'b110;
        end
    endtask

    // Drive inputs, take one clk edge, sample 1 time unit later.
    task automatic step(input bit en, input logic [23:0] d);
        pclk_en  = en;
        vga_data = d;
        @(posedge clk);
        #1;
        model_edge(en, d);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (act_vec !== RST_VEC) $display("FAIL reset_state got=%h exp=%h", act_vec, RST_VEC);
        else n_pass++;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_full_frame();
        int fs1 = -1, fs2 = -1, nval = 0, nhs = 0, nvs = 0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            step(1'b1, 24'($urandom));
            n_checks++;
            if (act_vec !== exp_vec()) $display("FAIL full_frame cyc=%0d got=%h exp=%h", i, act_vec, exp_vec());
            else n_pass++;
            if (frame_start) begin
                if (fs1 < 0) fs1 = i;
                else if (fs2 < 0) fs2 = i;
            end
            if (fs1 >= 0 && fs2 < 0) begin
                nval += int'(valid);
                nhs  += int'(!hsync);
                nvs  += int'(!vsync);
            end
        end
        n_checks++;
        if (fs2 - fs1 != FRAME) $display("FAIL frame_period got=%0d exp=%0d", fs2 - fs1, FRAME);
        else n_pass++;
        n_checks++;
        if (nval != (HAE - HAS) * (VAE - VAS)) $display("FAIL valid_count got=%0d exp=%0d", nval, (HAE - HAS) * (VAE - VAS));
        else n_pass++;
        n_checks++;
        if (nhs != VT * HS) $display("FAIL hsync_low_total got=%0d exp=%0d", nhs, VT * HS);
        else n_pass++;
        n_checks++;
        if (nvs != VS * HT) $display("FAIL vsync_low_total got=%0d exp=%0d", nvs, VS * HT);
        else n_pass++;
    endtask

    task automatic test_blank_timing();
        int v_rise = -1, b_rise = -1, c_rise = -1;
        bit pv = 1'b1, pb = 1'b1, pc = 1'b1;
        for (int i = 0; i < FRAME + 2 * HT; i++) begin
            step(1'b1, 24'hFFFFFF);
            n_checks++;
            if (act_vec !== exp_vec()) $display("FAIL blank_timing cyc=%0d got=%h exp=%h", i, act_vec, exp_vec());
            else n_pass++;
            if (v_rise < 0 && valid && !pv) v_rise = i;
            if (v_rise >= 0 && b_rise < 0 && blank_n && !pb) b_rise = i;
            if (v_rise >= 0 && c_rise < 0 && (act_vec[23:0] == 24'hFFFFFF) && !pc) c_rise = i;
            pv = valid;
            pb = blank_n;
            pc = (act_vec[23:0] == 24'hFFFFFF);
        end
        n_checks++;
        if (v_rise < 0 || b_rise - v_rise != D) $display("FAIL blank_rise_delay got=%0d exp=%0d", b_rise - v_rise, D);
        else n_pass++;
        n_checks++;
        if (v_rise < 0 || c_rise - v_rise != D + 1) $display("FAIL colour_rise_delay got=%0d exp=%0d", c_rise - v_rise, D + 1);
        else n_pass++;
    endtask

    task automatic test_random_enable();
        for (int i = 0; i < 6 * FRAME; i++) begin
            step(1'($urandom), 24'($urandom));
            n_checks++;
            if (act_vec !== exp_vec()) $display("FAIL random_enable cyc=%0d got=%h exp=%h", i, act_vec, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_toggle_enable();
        int fs1 = -1, fs2 = -1, lo_start = -1, lo_width = -1;
        bit ph;
        ph = hsync;
        for (int i = 0; i < 4 * FRAME + 8; i++) begin
            step(i[0] == 1'b0, 24'($urandom));
            n_checks++;
            if (act_vec !== exp_vec()) $display("FAIL toggle_enable cyc=%0d got=%h exp=%h", i, act_vec, exp_vec());
            else n_pass++;
            if (frame_start) begin
                if (fs1 < 0) fs1 = i;
                else if (fs2 < 0) fs2 = i;
            end
            if (ph && !hsync && lo_start < 0) lo_start = i;
            if (!ph && hsync && lo_start >= 0 && lo_width < 0) lo_width = i - lo_start;
            ph = hsync;
        end
        n_checks++;
        if (fs2 - fs1 != 2 * FRAME) $display("FAIL toggle_frame_period got=%0d exp=%0d", fs2 - fs1, 2 * FRAME);
        else n_pass++;
        n_checks++;
        if (lo_width != 2 * HS) $display("FAIL toggle_hsync_width got=%0d exp=%0d", lo_width, 2 * HS);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int guard = 0, first_fs = -1;
        while (!(m_x(m_n) == HT / 2 && m_y(m_n) == VT / 2) && guard < 2 * FRAME) begin
            step(1'b1, 24'($urandom));
            guard++;
        end
        n_checks++;
        if (guard >= 2 * FRAME) $display("FAIL async_reset_reach got=%0d exp=<%0d", guard, 2 * FRAME);
        else n_pass++;
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (act_vec !== RST_VEC) $display("FAIL async_reset_immediate got=%h exp=%h", act_vec, RST_VEC);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 1; i <= FRAME + 2; i++) begin
            step(1'b1, 24'($urandom));
            n_checks++;
            if (act_vec !== exp_vec()) $display("FAIL after_reset cyc=%0d got=%h exp=%h", i, act_vec, exp_vec());
            else n_pass++;
            if (frame_start && first_fs < 0) first_fs = i;
        end
        n_checks++;
        if (first_fs != FRAME) $display("FAIL first_frame_after_reset got=%0d exp=%0d", first_fs, FRAME);
        else n_pass++;
    endtask

    task automatic test_wrap_corner();
        int guard = 0;
        while ((m_n % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
            step(1'($urandom), 24'($urandom));
            guard++;
        end
        step(1'b0, 24'($urandom));
        step(1'b1, 24'($urandom));
        n_checks++;
        if (act_vec !== exp_vec()) $display("FAIL wrap_vec got=%h exp=%h", act_vec, exp_vec());
        else n_pass++;
        n_checks++;
        if ({frame_start, valid, h_addr, v_addr} !== {1'b1, 1'b0, 20'd0})
            $display("FAIL wrap_corner got=%b exp=%b", {frame_start, valid, h_addr, v_addr}, {1'b1, 1'b0, 20'd0});
        else n_pass++;
        step(1'b0, 24'($urandom));
        n_checks++;
        if (frame_start !== 1'b0 || act_vec !== exp_vec()) $display("FAIL wrap_pulse_end got=%h exp=%h", act_vec, exp_vec());
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_frame();
        test_blank_timing();
        test_random_enable();
        test_toggle_enable();
        test_async_reset();
        test_wrap_corner();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
